// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - decode, E..W control register chain and halt/drain FSM
module ctrl_pipe #(
  parameter int IW    = 16,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] instD,
  input  logic          validD,
  input  logic          stallD,
  input  logic          z,
  input  logic          s,
  input  logic          v,
  input  logic          restart,
  output logic          acceptD,
  output logic          flushD,
  output logic          pcsrcE,
  output logic [3:0]    alucontrolE,
  output logic          alusrcE,
  output logic          shiftE,
  output logic          liE,
  output logic          addiE,
  output logic          inE,
  output logic          outE,
  output logic          memwriteM,
  output logic          regwriteM,
  output logic          memtoregW,
  output logic          regwriteW,
  output logic          halted,
  output logic [1:0]    state
);

  typedef struct packed {
    logic       valid;
    logic [3:0] alucontrol;
    logic       alusrc;
    logic       shift;
    logic       li;
    logic       addi;
    logic       inp;
    logic       outp;
    logic       memwrite;
    logic       regwrite;
    logic       memtoreg;
    logic       br;
    logic       be;
    logic       blt;
    logic       ble;
    logic       bne;
  } bundle_t;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  localparam int LAST = DEPTH - 2;
  localparam int MIDX = DEPTH - 3;

  logic [15:0] w_f;
  logic [1:0]  w_op1;
  logic [2:0]  w_op2;
  logic [2:0]  w_cond;
  logic [3:0]  w_op3;
  bundle_t     w_dec;
  bundle_t     w_enter_e;
  logic        w_hlt;
  logic        w_pcsrc;
  logic        w_accept;
  logic        w_unused;

  bundle_t     r_pipe [DEPTH-1];
  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt_nxt;

  assign w_f    = instD[IW-1:IW-16];
  assign w_op1  = w_f[15:14];
  assign w_op2  = w_f[13:11];
  assign w_cond = w_f[10:8];
  assign w_op3  = w_f[7:4];

  always_comb begin
    w_dec       = '0;
    w_dec.valid = 1'b1;
    w_hlt       = 1'b0;
    case (w_op1)
      2'b00: begin
        w_dec.alusrc   = 1'b1;
        w_dec.memtoreg = 1'b1;
        w_dec.regwrite = 1'b1;
      end
      2'b01: begin
        w_dec.alusrc   = 1'b1;
        w_dec.memwrite = 1'b1;
      end
      2'b10: begin
        case (w_op2)
          3'b000: begin
            w_dec.li       = 1'b1;
            w_dec.regwrite = 1'b1;
          end
          3'b001: begin
            w_dec.addi     = 1'b1;
            w_dec.alusrc   = 1'b1;
            w_dec.regwrite = 1'b1;
          end
          3'b100: w_dec.br = 1'b1;
          3'b111: begin
            case (w_cond)
              3'b000:  w_dec.be  = 1'b1;
              3'b001:  w_dec.blt = 1'b1;
              3'b010:  w_dec.ble = 1'b1;
              3'b011:  w_dec.bne = 1'b1;
              default: ;
            endcase
          end
          default: ;
        endcase
      end
      default: begin
        w_dec.alucontrol = w_op3;
        w_dec.regwrite   = (w_op3 <= 4'd4) || (w_op3 == 4'd6) ||
                           ((w_op3 >= 4'd8) && (w_op3 <= 4'd12));
        w_dec.shift      = (w_op3[3:2] == 2'b10);
        w_dec.inp        = (w_op3 == 4'd12);
        w_dec.outp       = (w_op3 == 4'd13);
        w_hlt            = (w_op3 == 4'd15);
      end
    endcase
  end

  // Branch resolution is combinational on the E register so a taken branch kills D in the same cycle.
  assign w_pcsrc = r_pipe[0].valid &
                   (r_pipe[0].br | (r_pipe[0].be & z) | (r_pipe[0].blt & (s ^ v)) |
                    (r_pipe[0].ble & (z | (s ^ v))) | (r_pipe[0].bne & ~z));

  assign w_accept  = validD & ~stallD & ~w_pcsrc & (r_state == S_RUN);
  assign w_enter_e = (w_accept && !w_hlt) ? w_dec : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH-1; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= w_enter_e;
      for (int i = 1; i < DEPTH-1; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RUN;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The drain counter holds the older instructions' exit: DEPTH-1 cycles empties E..W.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_RUN: begin
        if (w_accept && w_hlt) begin
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = 3'd0;
        end
      end
      S_DRAIN: begin
        if (r_cnt == 3'(DEPTH-2)) begin
          w_state_nxt = S_HALTED;
          w_cnt_nxt   = 3'd0;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      S_HALTED: begin
        if (restart) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  assign acceptD     = w_accept;
  assign flushD      = w_pcsrc;
  assign pcsrcE      = w_pcsrc;
  assign alucontrolE = r_pipe[0].alucontrol;
  assign alusrcE     = r_pipe[0].alusrc;
  assign shiftE      = r_pipe[0].shift;
  assign liE         = r_pipe[0].li;
  assign addiE       = r_pipe[0].addi;
  assign inE         = r_pipe[0].inp;
  assign outE        = r_pipe[0].outp;
  assign memwriteM   = r_pipe[MIDX].memwrite;
  assign regwriteM   = r_pipe[MIDX].regwrite;
  assign memtoregW   = r_pipe[LAST].memtoreg;
  assign regwriteW   = r_pipe[LAST].regwrite;
  assign halted      = (r_state == S_HALTED);
  assign state       = r_state;

  assign w_unused = ^{instD, r_pipe[LAST]};

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - scoreboard bench for ctrl_pipe at DEPTH 4 and DEPTH 6
module tb_ctrl_pipe;

  typedef struct packed {
    logic       valid;
    logic [3:0] alu;
    logic       alusrc, shift, li, addi, inp, outp;
    logic       memwrite, regwrite, memtoreg;
    logic       br, be, blt, ble, bne;
  } ctl_t;

  typedef struct packed {
    logic       acc, fl, pc;
    logic [3:0] alu;
    logic       alusrc, shift, li, addi, inp, outp;
    logic       memwriteM, regwriteM, memtoregW, regwriteW;
    logic       halted;
    logic [1:0] state;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, validD, stallD, z, s, v, restart;
  logic [15:0] instD4;
  logic [19:0] instD6;
  obs_t        o4, o6;

  ctrl_pipe #(.IW(16), .DEPTH(4)) u4 (
    .clk(clk), .reset(reset), .instD(instD4), .validD(validD), .stallD(stallD),
    .z(z), .s(s), .v(v), .restart(restart),
    .acceptD(o4.acc), .flushD(o4.fl), .pcsrcE(o4.pc), .alucontrolE(o4.alu),
    .alusrcE(o4.alusrc), .shiftE(o4.shift), .liE(o4.li), .addiE(o4.addi),
    .inE(o4.inp), .outE(o4.outp), .memwriteM(o4.memwriteM), .regwriteM(o4.regwriteM),
    .memtoregW(o4.memtoregW), .regwriteW(o4.regwriteW), .halted(o4.halted), .state(o4.state)
  );

  ctrl_pipe #(.IW(20), .DEPTH(6)) u6 (
    .clk(clk), .reset(reset), .instD(instD6), .validD(validD), .stallD(stallD),
    .z(z), .s(s), .v(v), .restart(restart),
    .acceptD(o6.acc), .flushD(o6.fl), .pcsrcE(o6.pc), .alucontrolE(o6.alu),
    .alusrcE(o6.alusrc), .shiftE(o6.shift), .liE(o6.li), .addiE(o6.addi),
    .inE(o6.inp), .outE(o6.outp), .memwriteM(o6.memwriteM), .regwriteM(o6.regwriteM),
    .memtoregW(o6.memtoregW), .regwriteW(o6.regwriteW), .halted(o6.halted), .state(o6.state)
  );

  // Reference model: per instance, list of bundles by age in stages, plus FSM as state and cycles-in-drain.
  ctl_t mp   [2][6];
  int   mst  [2];
  int   mcnt [2];
  obs_t q4[$], q6[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc_no = 0;

  function automatic int depth_of(int d);
    return (d == 0) ? 4 : 6;
  endfunction

  function automatic ctl_t decode(logic [15:0] f);
    ctl_t c = '0;
    int op1 = int'(f[15:14]);
    int op2 = int'(f[13:11]);
    int cnd = int'(f[10:8]);
    int op3 = int'(f[7:4]);
    c.valid = 1'b1;
    if (op1 == 0) begin c.alusrc = 1; c.memtoreg = 1; c.regwrite = 1; end
    else if (op1 == 1) begin c.alusrc = 1; c.memwrite = 1; end
    else if (op1 == 2) begin
      if (op2 == 0) begin c.li = 1; c.regwrite = 1; end
      if (op2 == 1) begin c.addi = 1; c.alusrc = 1; c.regwrite = 1; end
      if (op2 == 4) c.br = 1;
      if (op2 == 7) begin
        c.be  = (cnd == 0);
        c.blt = (cnd == 1);
        c.ble = (cnd == 2);
        c.bne = (cnd == 3);
      end
    end else begin
      c.alu      = 4'(op3);
      c.regwrite = op3 inside {[0:4], 6, [8:12]};
      c.shift    = op3 inside {[8:11]};
      c.inp      = (op3 == 12);
      c.outp     = (op3 == 13);
    end
    return c;
  endfunction

  function automatic bit is_hlt(logic [15:0] f);
    return (f[15:14] == 2'b11) && (f[7:4] == 4'hF);
  endfunction

  function automatic bit taken(ctl_t e, bit zz, bit ss, bit vv);
    bit lt = (ss != vv);
    return e.valid && (e.br || (e.be && zz) || (e.blt && lt) || (e.ble && (zz || lt)) || (e.bne && !zz));
  endfunction

  function automatic obs_t expect_obs(int d, bit vld, bit stl, logic [15:0] f, bit zz, bit ss, bit vv);
    obs_t o  = '0;
    int   dp = depth_of(d);
    ctl_t e  = mp[d][0];
    bit   tk = taken(e, zz, ss, vv);
    o.acc       = vld && !stl && !tk && (mst[d] == 0);
    o.fl        = tk;
    o.pc        = tk;
    o.alu       = e.alu;
    o.alusrc    = e.alusrc;
    o.shift     = e.shift;
    o.li        = e.li;
    o.addi      = e.addi;
    o.inp       = e.inp;
    o.outp      = e.outp;
    o.memwriteM = mp[d][dp-3].memwrite;
    o.regwriteM = mp[d][dp-3].regwrite;
    o.memtoregW = mp[d][dp-2].memtoreg;
    o.regwriteW = mp[d][dp-2].regwrite;
    o.halted    = (mst[d] == 2);
    o.state     = 2'(mst[d]);
    return o;
  endfunction

  task automatic model_step(int d, bit rst, bit vld, bit stl, logic [15:0] f, bit zz, bit ss, bit vv, bit rs);
    int dp  = depth_of(d);
    bit acc = vld && !stl && !taken(mp[d][0], zz, ss, vv) && (mst[d] == 0);
    if (rst) begin
      for (int k = 0; k < 6; k++) mp[d][k] = '0;
      mst[d]  = 0;
      mcnt[d] = 0;
      return;
    end
    for (int k = dp-2; k > 0; k--) mp[d][k] = mp[d][k-1];
    mp[d][0] = (acc && !is_hlt(f)) ? decode(f) : '0;
    if (mst[d] == 0) begin
      if (acc && is_hlt(f)) begin mst[d] = 1; mcnt[d] = 1; end
    end else if (mst[d] == 1) begin
      if (mcnt[d] == dp-1) mst[d] = 2;
      else mcnt[d]++;
    end else if (rs) begin
      mst[d] = 0;
    end
  endtask

  task automatic cyc(bit rst, bit vld, bit stl, logic [15:0] f, bit zz, bit ss, bit vv, bit rs);
    logic [3:0] lo = 4'($urandom);
    reset = rst; validD = vld; stallD = stl; z = zz; s = ss; v = vv; restart = rs;
    instD4 = f;
    instD6 = {f, lo};
    q4.push_back(expect_obs(0, vld, stl, f, zz, ss, vv));
    q6.push_back(expect_obs(1, vld, stl, f, zz, ss, vv));
    @(posedge clk);
    model_step(0, rst, vld, stl, f, zz, ss, vv, rs);
    model_step(1, rst, vld, stl, f, zz, ss, vv, rs);
    cyc_no++;
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 16'h0000, 0, 0, 0, 0);
  endtask

  task automatic chk(string name, int dp, logic [15:0] act, logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s depth=%0d cycle=%0d got=%h want=%h", name, dp, cyc_no, act, exp);
    end
  endtask

  task automatic compare(int dp, obs_t a, obs_t e);
    chk("acceptD", dp, 16'(a.acc), 16'(e.acc));
    chk("flushD_pcsrcE", dp, 16'({a.fl, a.pc}), 16'({e.fl, e.pc}));
    chk("E_controls", dp, 16'({a.alu, a.alusrc, a.shift, a.li, a.addi, a.inp, a.outp}),
                          16'({e.alu, e.alusrc, e.shift, e.li, e.addi, e.inp, e.outp}));
    chk("M_controls", dp, 16'({a.memwriteM, a.regwriteM}), 16'({e.memwriteM, e.regwriteM}));
    chk("W_controls", dp, 16'({a.memtoregW, a.regwriteW}), 16'({e.memtoregW, e.regwriteW}));
    chk("state_halted", dp, 16'({a.halted, a.state}), 16'({e.halted, e.state}));
  endtask

  initial begin
    obs_t e;
    forever begin
      @(negedge clk);
      if (q4.size() > 0) begin e = q4.pop_front(); compare(4, o4, e); end
      if (q6.size() > 0) begin e = q6.pop_front(); compare(6, o6, e); end
    end
  end

  function automatic logic [15:0] rnd_f();
    logic [15:0] r = 16'($urandom);
    logic [3:0]  op3 = 4'($urandom_range(0, 15));
    case ($urandom_range(0, 7))
      0: return {2'b00, r[13:0]};
      1: return {2'b01, r[13:0]};
      2: return {5'b10000, r[10:0]};
      3: return {5'b10001, r[10:0]};
      4: return {5'b10100, r[10:0]};
      5: return {5'b10111, r[10:0]};
      6: return {2'b11, r[13:8], op3, r[3:0]};
      default: return r;
    endcase
  endfunction

  initial begin
    reset = 1'b1; validD = 0; stallD = 0; z = 0; s = 0; v = 0; restart = 0;
    instD4 = '0; instD6 = '0;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 6; k++) mp[d][k] = '0;
      mst[d] = 0; mcnt[d] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    cyc(1, 1, 0, 16'h0000, 0, 0, 0, 0);
    cyc(1, 0, 0, 16'h0000, 0, 0, 0, 0);
    // load through the whole pipe
    cyc(0, 1, 0, 16'h0000, 0, 0, 0, 0);
    idle(6);
    // be taken, then not taken
    cyc(0, 1, 0, 16'hB800, 0, 0, 0, 0);
    cyc(0, 1, 0, 16'h0000, 1, 0, 0, 0);
    idle(2);
    cyc(0, 1, 0, 16'hB800, 0, 0, 0, 0);
    cyc(0, 1, 0, 16'h4000, 0, 0, 0, 0);
    idle(5);
    // ble taken against a stall
    cyc(0, 1, 0, 16'hBA00, 0, 0, 0, 0);
    cyc(0, 1, 1, 16'hC010, 0, 1, 0, 0);
    idle(3);
    // halt, drain, restart ignored while draining, then restart
    cyc(0, 1, 0, 16'hC0F0, 0, 0, 0, 0);
    cyc(0, 1, 0, 16'h0000, 0, 0, 0, 1);
    idle(7);
    cyc(0, 1, 0, 16'h0000, 0, 0, 0, 1);
    cyc(0, 1, 0, 16'hC080, 0, 0, 0, 0);
    idle(6);
    // HLT killed by br in E
    cyc(0, 1, 0, 16'hA000, 0, 0, 0, 0);
    cyc(0, 1, 0, 16'hC0F0, 0, 0, 0, 0);
    idle(3);
    // reset in DRAIN, then a load to check W latency
    cyc(0, 1, 0, 16'h8800, 0, 0, 0, 0);
    cyc(0, 1, 0, 16'hC0F0, 0, 0, 0, 0);
    idle(2);
    cyc(1, 0, 0, 16'h0000, 0, 0, 0, 0);
    cyc(0, 1, 0, 16'h0000, 0, 0, 0, 0);
    idle(6);
    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 8), ($urandom_range(0, 4) == 0),
          rnd_f(), 1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
    end
    idle(2);
    @(negedge clk);
    #1;
    n_vec++;
    if ((q4.size() + q6.size()) != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got=%0d want=0", q4.size() + q6.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 The block SHALL have parameter IW, default 16, meaning instruction width (IW >= 16); decode uses bits [IW-1:IW-16] only.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the stage count D..W (legal 4..6); E = stage 1, M = stage DEPTH-2, W = stage DEPTH-1.
REQ-003 The block SHALL have one clock, and its reset SHALL be synchronous and active-high.
REQ-004 The ports SHALL be, in order:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- instD  in  IW  instruction in D
- validD  in  1  instD valid
- stallD  in  1  hazard hold of D
- z, s, v  in  1 each  ALU flags of the E-stage instruction
- restart  in  1  leave HALTED
- acceptD  out  1  instD consumed this cycle
- flushD  out  1  kill D/F contents
- pcsrcE  out  1  branch taken in E
- alucontrolE  out  4  ALU op
- alusrcE, shiftE, liE, addiE, inE, outE  out  1 each  E controls
- memwriteM, regwriteM  out  1 each  M controls
- memtoregW, regwriteW  out  1 each  W controls
- halted  out  1  HALTED state
- state  out  2  FSM state: 0 RUN, 1 DRAIN, 2 HALTED

Function
REQ-005 Decode (f = instD[IW-1:IW-16]; op1 = f[15:14], op2 = f[13:11], cond = f[10:8], op3 = f[7:4]) SHALL be:
- op1=00: load (alusrc, memtoreg, regwrite).
- op1=01: store (alusrc, memwrite).
- op1=10, op2=000: li (li, regwrite).
- op1=10, op2=001: addi (addi, alusrc, regwrite).
- op1=10, op2=100: br.
- op1=10, op2=111: conditional branch; cond 000 be, 001 blt, 010 ble, 011 bne, other codes = nop.
- op1=11: ALU op; alucontrol = op3.
  - regwrite for op3 in {0-4, 6, 8-12}; op3=5 (cmp) sets no regwrite.
  - shift for op3 8-11; in for op3=12; out for op3=13; op3=15 = HLT.
- Other encodings: nop.
REQ-006 Decoded bundles SHALL advance through a DEPTH-1 entry register chain, one stage per cycle; E..W never stall.
REQ-007 Bubble (all controls 0, valid 0) SHALL enter E when any of the following holds: validD=0, stallD=1, flushD=1, or state != RUN.
REQ-008 acceptD SHALL equal validD & !stallD & !flushD & (state==RUN).
REQ-009 pcsrcE SHALL equal validE & (br | be&z | blt&(s^v) | ble&(z|(s^v)) | bne&!z), combinational from the E bundle and flags.
REQ-010 flushD SHALL equal pcsrcE; a taken branch overrides a simultaneous stallD, and instD is killed, not held.
REQ-011 FSM RUN->DRAIN SHALL occur when HLT is accepted in D; the HLT itself enters E as a bubble.
REQ-012 In DRAIN, a counter SHALL count DEPTH-1 cycles, then go to HALTED; a taken branch during DRAIN does not cancel it.
REQ-013 HALTED SHALL hold until restart=1, then return to RUN next cycle; restart in RUN/DRAIN SHALL be ignored.
REQ-014 A HLT in D while pcsrcE=1 SHALL be killed: no state change.
REQ-015 Outputs SHALL be taken from the register at their stage, with no extra latency: an instruction accepted at cycle t appears in E at t+1 and in W at t+DEPTH-1.

Reset
REQ-016 While reset=1, all bundle registers SHALL clear to bubble, state SHALL go to RUN, and the drain counter SHALL go to 0.
REQ-017 After reset, all outputs SHALL be 0 except acceptD, which follows validD.
REQ-018 Reset mid-DRAIN or in HALTED SHALL return to RUN next edge.

Verification
REQ-019 The bench SHALL cover load: DEPTH=4, instD=0x0000 accepted at t -> alusrcE=1 at t+1, regwriteM=1 at t+2, memtoregW=1 and regwriteW=1 at t+3.
REQ-020 The bench SHALL cover branch: be (f=0xB800) with z=1 in E -> pcsrcE=1 and flushD=1; next instD is not accepted; E next cycle = bubble. With z=0 -> pcsrcE=0.
REQ-021 The bench SHALL cover branch vs. stall: ble with s=1, v=0 and stallD=1 in the same cycle -> pcsrcE=1, acceptD=0, E next cycle = bubble.
REQ-022 The bench SHALL cover halt: HLT (f=0xC0F0) accepted at t, DEPTH=4 -> state=1 for t+1..t+3, halted=1 from t+4; restart=1 -> state=0 next cycle.
REQ-023 The bench SHALL cover HLT vs. taken branch: HLT in D while br in E -> state stays 0, halted=0.
REQ-024 The bench SHALL cover reset in DRAIN: assert reset during state=1 -> next cycle state=0, all stage controls 0; repeat for DEPTH=6, checking W latency of 5.
